// File: rtl/io_pkg.sv
// Shared I/O definitions for the board-input conditioning path and the
// processor I/O register block.
//   IO_WIDTH   : number of board input bits presented on fpga_in
//   db_state_t : per-bit debounce state; bit 1 of the encoding is the
//                accepted (stable) level
package io_pkg;

  localparam int IO_WIDTH = 9;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } db_state_t;

endpackage

// File: rtl/input_debounce_capture_if.sv
// Bus between the I/O register block (master) and the input debounce/capture
// block (slave).
//   raw_in       : asynchronous pad inputs (master -> slave)
//   clear_en     : one-cycle flag clear strobe (master -> slave)
//   clear_mask   : bits whose rise/fall flags clear on clear_en (master -> slave)
//   stable_out   : debounced level per bit (slave -> master, fpga_in)
//   rise_flags   : sticky 0->1 events since last clear (slave -> master)
//   fall_flags   : sticky 1->0 events since last clear (slave -> master)
//   change_pulse : one-cycle pulse after any stable bit changed (slave -> master)
//   irq          : any rise/fall flag pending (slave -> master)
interface input_debounce_capture_if
  import io_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH
);

  logic [WIDTH-1:0] raw_in;
  logic             clear_en;
  logic [WIDTH-1:0] clear_mask;
  logic [WIDTH-1:0] stable_out;
  logic [WIDTH-1:0] rise_flags;
  logic [WIDTH-1:0] fall_flags;
  logic             change_pulse;
  logic             irq;

  modport master (
    output raw_in, clear_en, clear_mask,
    input  stable_out, rise_flags, fall_flags, change_pulse, irq
  );

  modport slave (
    input  raw_in, clear_en, clear_mask,
    output stable_out, rise_flags, fall_flags, change_pulse, irq
  );

endinterface

// File: rtl/input_debounce_capture_debounce_bit.sv
// Single-bit conditioner: two-flop synchroniser, four-state debounce FSM and
// qualification counter.
//   clk, reset : clock and asynchronous active-high reset
//   raw        : asynchronous pad input
//   stable     : registered debounced level
//   rise_evt   : high in the cycle whose closing edge raises stable
//   fall_evt   : high in the cycle whose closing edge lowers stable
module debounce_bit
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise_evt,
  output logic fall_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last  = (cnt == CNT_LAST);

  // Events are decoded from the current state so the top level can set its
  // sticky flags on the same edge that updates stable.
  assign rise_evt = (state == WAIT_HI) && s2 && at_last;
  assign fall_evt = (state == WAIT_LO) && !s2 && at_last;

  // Synchroniser for the asynchronous pad input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive
  // differing samples; any return to the old level restarts qualification.
  // The counter tops out at CNT_LAST, where the FSM always leaves the wait
  // state, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      case (state)
        STABLE_LO: begin
          if (s2) begin
            state <= WAIT_HI;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HI: begin
          if (!s2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (at_last) begin
            state  <= STABLE_HI;
            cnt    <= '0;
            stable <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state <= WAIT_LO;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (s2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (at_last) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            stable <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= STABLE_LO;
          cnt    <= '0;
          stable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_debounce_capture.sv
// Board input conditioning: per-bit debounce plus sticky rise/fall event
// flags with masked clear, a change pulse and an interrupt request.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of input_debounce_capture_if (raw_in, clear_en,
//                clear_mask in; stable_out, rise_flags, fall_flags,
//                change_pulse, irq out)
module input_debounce_capture
  import io_pkg::*;
#(
  parameter int WIDTH           = IO_WIDTH,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input_debounce_capture_if.slave bus
);

  logic [WIDTH-1:0] stable_vec;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] clr;
  logic             change_q;
  logic             irq_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw      (bus.raw_in[i]),
      .stable   (stable_vec[i]),
      .rise_evt (rise_evt[i]),
      .fall_evt (fall_evt[i])
    );
  end

  assign clr = bus.clear_en ? bus.clear_mask : '0;

  // Clear is applied before set so an event arriving with a clear strobe is
  // kept. change_pulse and irq look at the already-updated stable/flag
  // registers, so they trail those by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q   <= '0;
      fall_q   <= '0;
      stable_d <= '0;
      change_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rise_q   <= (rise_q & ~clr) | rise_evt;
      fall_q   <= (fall_q & ~clr) | fall_evt;
      stable_d <= stable_vec;
      change_q <= |(stable_vec ^ stable_d);
      irq_q    <= |(rise_q | fall_q);
    end
  end

  assign bus.stable_out   = stable_vec;
  assign bus.rise_flags   = rise_q;
  assign bus.fall_flags   = fall_q;
  assign bus.change_pulse = change_q;
  assign bus.irq          = irq_q;

endmodule

// File: tb/tb_input_debounce_capture.sv
// Directed bench for input_debounce_capture with DEBOUNCE_CYCLES=4.
// Expected values are queued against an absolute edge number when stimulus
// is applied, and compared when that edge has been sampled.
module tb_input_debounce_capture;
  import io_pkg::*;

  localparam int W = IO_WIDTH;
  localparam int N = 4;

  localparam int SIG_STABLE = 0;
  localparam int SIG_RISE   = 1;
  localparam int SIG_FALL   = 2;
  localparam int SIG_CHANGE = 3;
  localparam int SIG_IRQ    = 4;

  typedef struct {
    int           due;
    int           sig;
    logic [W-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   edge_n     = 0;

  logic clk = 1'b0;
  logic reset;

  input_debounce_capture_if #(.WIDTH(W)) bus ();

  input_debounce_capture #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic string sig_name(input int sig);
    case (sig)
      SIG_STABLE: return "stable_out";
      SIG_RISE:   return "rise_flags";
      SIG_FALL:   return "fall_flags";
      SIG_CHANGE: return "change_pulse";
      default:    return "irq";
    endcase
  endfunction

  function automatic logic [W-1:0] observe(input int sig);
    case (sig)
      SIG_STABLE: return bus.stable_out;
      SIG_RISE:   return bus.rise_flags;
      SIG_FALL:   return bus.fall_flags;
      SIG_CHANGE: return {{(W-1){1'b0}}, bus.change_pulse};
      default:    return {{(W-1){1'b0}}, bus.irq};
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [W-1:0] obs,
                              input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int offset, input int sig, input logic [W-1:0] val);
    exp_t e;
    e.due = edge_n + offset;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  // Advance one rising edge, sample 1 time unit later, and retire every
  // scoreboard entry due at this edge.
  task automatic tick();
    int n;
    @(posedge clk);
    edge_n++;
    #1;
    n = sb_q.size();
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.due == edge_n)
        check_output($sformatf("%s@edge%0d", sig_name(e.sig), e.due),
                     observe(e.sig), e.val);
      else
        sb_q.push_back(e);
    end
  endtask

  task automatic tick_n(input int k);
    for (int j = 0; j < k; j++) tick();
  endtask

  task automatic apply_stimulus(input logic [W-1:0] raw, input logic ce,
                                input logic [W-1:0] mask);
    bus.raw_in     = raw;
    bus.clear_en   = ce;
    bus.clear_mask = mask;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    apply_stimulus(9'h000, 1'b0, 9'h000);
    tick_n(2);
    check_output("reset_stable", bus.stable_out, 9'h000);
    check_output("reset_rise", bus.rise_flags, 9'h000);
    check_output("reset_irq", {{(W-1){1'b0}}, bus.irq}, 9'h000);
    reset = 1'b0;

    // Idle inputs: nothing moves.
    $display("[TB] idle after reset");
    for (int k = 1; k <= 10; k++) expect_at(k, SIG_STABLE, 9'h000);
    expect_at(10, SIG_RISE, 9'h000);
    expect_at(10, SIG_FALL, 9'h000);
    expect_at(10, SIG_CHANGE, 9'h000);
    expect_at(10, SIG_IRQ, 9'h000);
    tick_n(10);

    // Clean rise on bit 0: accepted exactly 2+N edges after it is driven.
    $display("[TB] clean rise on bit 0");
    apply_stimulus(9'h001, 1'b0, 9'h000);
    expect_at(N+1, SIG_STABLE, 9'h000);
    expect_at(N+2, SIG_STABLE, 9'h001);
    expect_at(N+1, SIG_RISE, 9'h000);
    expect_at(N+2, SIG_RISE, 9'h001);
    expect_at(N+2, SIG_CHANGE, 9'h000);
    expect_at(N+3, SIG_CHANGE, 9'h001);
    expect_at(N+4, SIG_CHANGE, 9'h000);
    expect_at(N+2, SIG_IRQ, 9'h000);
    expect_at(N+3, SIG_IRQ, 9'h001);
    tick_n(10);

    // Bouncing bit 3 never qualifies.
    $display("[TB] bounce on bit 3");
    for (int k = 1; k <= 12; k++) expect_at(k, SIG_STABLE, 9'h001);
    expect_at(12, SIG_RISE, 9'h001);
    expect_at(12, SIG_FALL, 9'h000);
    expect_at(12, SIG_CHANGE, 9'h000);
    expect_at(12, SIG_IRQ, 9'h001);
    apply_stimulus(9'h009, 1'b0, 9'h000); tick();
    apply_stimulus(9'h001, 1'b0, 9'h000); tick();
    apply_stimulus(9'h009, 1'b0, 9'h000); tick();
    apply_stimulus(9'h001, 1'b0, 9'h000); tick_n(9);

    // Masked clear, then irq drops a cycle later.
    $display("[TB] masked clear");
    apply_stimulus(9'h001, 1'b1, 9'h001);
    expect_at(1, SIG_RISE, 9'h000);
    expect_at(1, SIG_IRQ, 9'h001);
    expect_at(2, SIG_IRQ, 9'h000);
    tick();
    apply_stimulus(9'h001, 1'b0, 9'h000);
    tick_n(3);

    // Bit 0 falls, then rises again with a clear-all strobe on the rise edge.
    $display("[TB] clear coinciding with new rise");
    apply_stimulus(9'h000, 1'b0, 9'h000);
    expect_at(N+1, SIG_STABLE, 9'h001);
    expect_at(N+2, SIG_STABLE, 9'h000);
    expect_at(N+2, SIG_FALL, 9'h001);
    tick_n(8);
    apply_stimulus(9'h001, 1'b0, 9'h000);
    expect_at(N+2, SIG_STABLE, 9'h001);
    expect_at(N+2, SIG_RISE, 9'h001);
    expect_at(N+2, SIG_FALL, 9'h000);
    expect_at(N+3, SIG_RISE, 9'h001);
    expect_at(N+4, SIG_IRQ, 9'h001);
    tick_n(N+1);
    apply_stimulus(9'h001, 1'b1, 9'h1FF);
    tick();
    apply_stimulus(9'h001, 1'b0, 9'h000);
    tick_n(4);

    // Return bit 0 low and clear everything.
    apply_stimulus(9'h000, 1'b0, 9'h000);
    tick_n(8);
    apply_stimulus(9'h000, 1'b1, 9'h1FF);
    expect_at(1, SIG_RISE, 9'h000);
    expect_at(1, SIG_FALL, 9'h000);
    expect_at(2, SIG_IRQ, 9'h000);
    tick();
    apply_stimulus(9'h000, 1'b0, 9'h000);
    tick_n(2);

    // All bits together: up for 8 cycles, then down.
    $display("[TB] all bits rise and fall");
    apply_stimulus(9'h1FF, 1'b0, 9'h000);
    expect_at(N+1, SIG_STABLE, 9'h000);
    expect_at(N+2, SIG_STABLE, 9'h1FF);
    expect_at(N+2, SIG_RISE, 9'h1FF);
    expect_at(N+3, SIG_CHANGE, 9'h001);
    expect_at(N+4, SIG_CHANGE, 9'h000);
    expect_at(8+N+1, SIG_STABLE, 9'h1FF);
    expect_at(8+N+2, SIG_STABLE, 9'h000);
    expect_at(8+N+2, SIG_FALL, 9'h1FF);
    expect_at(8+N+2, SIG_RISE, 9'h1FF);
    expect_at(8+N+3, SIG_CHANGE, 9'h001);
    tick_n(8);
    apply_stimulus(9'h000, 1'b0, 9'h000);
    tick_n(10);
    apply_stimulus(9'h000, 1'b1, 9'h1FF);
    expect_at(1, SIG_RISE, 9'h000);
    expect_at(2, SIG_IRQ, 9'h000);
    tick();
    apply_stimulus(9'h000, 1'b0, 9'h000);
    tick_n(3);

    // Reset partway through qualification discards the partial count.
    $display("[TB] reset mid-qualification");
    apply_stimulus(9'h005, 1'b0, 9'h000);
    tick_n(N+1);
    #3 reset = 1'b1;
    #1;
    check_output("midreset_stable", bus.stable_out, 9'h000);
    check_output("midreset_rise", bus.rise_flags, 9'h000);
    tick_n(2);
    reset = 1'b0;
    expect_at(N+1, SIG_STABLE, 9'h000);
    expect_at(N+2, SIG_STABLE, 9'h005);
    expect_at(N+2, SIG_RISE, 9'h005);
    tick_n(N+4);

    guard = 0;
    while (sb_q.size() > 0 && guard < 50) begin
      tick();
      guard++;
    end
    check_output("scoreboard_drained", W'(sb_q.size()), 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
